tt_um_lathe_spindle_mon: RTL and testbench

Spindle feedback monitor for the manual-lathe retrofit. It receives the contactor command that the lathe start controller drives and the spindle tach/proximity pulse train, and confirms the spindle actually spins. It detects failure to start and stall in run, and reports status plus the measured pulse rate. It sits on the return path of the same interface: the controller commands the spindle, this block checks the result.

---
 rtl/lathe_mon_pkg.sv | 22 ++
 rtl/sync_edge.sv | 47 ++++
 rtl/tt_um_lathe_spindle_mon.sv | 151 +++++++++++++++
 tb/tb_tt_um_lathe_spindle_mon.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/lathe_mon_pkg.sv
// Shared types and defaults for the lathe spindle feedback monitor.
package lathe_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPINUP  = 2'd1,
    ST_RUNNING = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_NOSTART = 2'd1;
  localparam logic [1:0] FC_STALL   = 2'd2;

  localparam int MIN_PULSES_DEF     = 4;
  localparam int SPINUP_WINDOWS_DEF = 3;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchronizer, optionally followed by a registered rising-edge pulse
// (edge appears 3 cycles after the pin rises).
module sync_edge #(
  parameter int W    = 1,
  parameter bit EDGE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (ena) begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

  generate
    if (EDGE) begin : g_edge
      logic [W-1:0] s3_q, rise_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s3_q   <= '0;
          rise_q <= '0;
        end else if (ena) begin
          s3_q   <= s2_q;
          rise_q <= s2_q & ~s3_q;
        end
      end
      assign rise_o = rise_q;
    end else begin : g_no_edge
      assign rise_o = '0;
    end
  endgenerate

endmodule

// File: rtl/tt_um_lathe_spindle_mon.sv
// Spindle feedback monitor: counts tach edges per gate window and flags
// no-start / stall against the contactor command.
module tt_um_lathe_spindle_mon
  import lathe_mon_pkg::*;
#(
`ifdef COCOTB_SIM
  parameter int GATE_CYCLES    = 16,
`else
  parameter int GATE_CYCLES    = 50_000_000,
`endif
  parameter int MIN_PULSES     = MIN_PULSES_DEF,
  parameter int SPINUP_WINDOWS = SPINUP_WINDOWS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int GW = $clog2(GATE_CYCLES) + 1;
  localparam int WW = $clog2(SPINUP_WINDOWS) + 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [7:0]    MIN_P     = 8'(MIN_PULSES);
  localparam logic [WW-1:0] SPIN_WIN  = WW'(SPINUP_WINDOWS);

  logic [1:0] ctl_s, ctl_rise_unused;
  logic       tach_edge;
  logic       cmd_s, clr_s;

  sync_edge #(.W(2), .EDGE(1'b0)) u_sync_ctl (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .d_i({ui_in[2], ui_in[0]}), .q_o(ctl_s), .rise_o(ctl_rise_unused)
  );

  logic tach_s_unused;
  sync_edge #(.W(1), .EDGE(1'b1)) u_sync_tach (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .d_i(ui_in[1]), .q_o(tach_s_unused), .rise_o(tach_edge)
  );

  assign cmd_s = ctl_s[0];
  assign clr_s = ctl_s[1];

  state_e        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic [GW-1:0] gate_q, gate_d;
  logic [7:0]    pulse_q, pulse_d;
  logic [WW-1:0] win_q, win_d;
  logic [7:0]    last_q, last_d;
  logic          armed_q, armed_d;
  logic [7:0]    uo_q, uo_d;

  logic       win_close;
  logic [7:0] closing;
  logic [WW-1:0] win_inc;

  assign win_close = (gate_q == GATE_LAST);
  assign closing   = sat_inc(pulse_q, tach_edge);
  assign win_inc   = win_q + 1'b1;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    gate_d  = '0;
    pulse_d = '0;
    win_d   = '0;
    last_d  = last_q;
    // Restart needs cmd seen low while idle, so a held cmd cannot re-arm.
    armed_d = (state_q == ST_IDLE) && (armed_q || !cmd_s);

    if (state_q == ST_SPINUP || state_q == ST_RUNNING) begin
      win_d = win_q;
      if (!win_close) begin
        gate_d  = gate_q + 1'b1;
        pulse_d = sat_inc(pulse_q, tach_edge);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_s && armed_q) state_d = ST_SPINUP;
      end
      ST_SPINUP: begin
        if (!cmd_s) begin
          state_d = ST_IDLE;
        end else if (win_close) begin
          last_d = closing;
          win_d  = win_inc;
          if (closing >= MIN_P) begin
            state_d = ST_RUNNING;
          end else if (win_inc >= SPIN_WIN) begin
            state_d = ST_FAULT;
            code_d  = FC_NOSTART;
          end
        end
      end
      ST_RUNNING: begin
        if (!cmd_s) begin
          state_d = ST_IDLE;
        end else if (win_close) begin
          last_d = closing;
          if (closing < MIN_P) begin
            state_d = ST_FAULT;
            code_d  = FC_STALL;
          end
        end
      end
      default: begin
        if (clr_s && !cmd_s) begin
          state_d = ST_IDLE;
          code_d  = FC_NONE;
        end
      end
    endcase

    uo_d = {2'b00, state_d, code_d, state_d == ST_FAULT, state_d == ST_RUNNING};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= FC_NONE;
      gate_q  <= '0;
      pulse_q <= '0;
      win_q   <= '0;
      last_q  <= '0;
      armed_q <= 1'b0;
      uo_q    <= '0;
    end else if (ena) begin
      state_q <= state_d;
      code_q  <= code_d;
      gate_q  <= gate_d;
      pulse_q <= pulse_d;
      win_q   <= win_d;
      last_q  <= last_d;
      armed_q <= armed_d;
      uo_q    <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = last_q;
  assign uio_oe  = 8'hFF;

  wire unused_ok = &{1'b0, uio_in, ui_in[7:3], ctl_rise_unused, tach_s_unused};

endmodule

// File: tb/tb_tt_um_lathe_spindle_mon.sv
// Scoreboard bench for the spindle monitor at sim parameters (16/4/3).
module tb_tt_um_lathe_spindle_mon;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       cmd = 1'b0, tach = 1'b0, clr = 1'b0;
  logic [4:0] spare = '0;
  logic [7:0] uio_in = '0;
  wire  [7:0] ui_in = {spare, clr, tach, cmd};
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_lathe_spindle_mon #(.GATE_CYCLES(16), .MIN_PULSES(4), .SPINUP_WINDOWS(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] uo;
    logic [7:0] uio;
    bit         use_uio;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   tach_until = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h want 0x%02h", tag, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input string tag, input logic [7:0] uo,
                           input logic [7:0] uio, input bit use_uio);
    exp_t e;
    e.cyc = c; e.tag = tag; e.uo = uo; e.uio = uio; e.use_uio = use_uio;
    sbq.push_back(e);
  endtask

  // One cycle: sample at negedge, retire due expectations, then drive tach.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      chk({e.tag, "_uo"}, uo_out, e.uo);
      if (e.use_uio) chk({e.tag, "_uio"}, uio_out, e.uio);
    end
    tach = (cyc < tach_until) ? ~cyc[1] : 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start(input int tu);
    @(negedge clk);
    rst_n = 1'b0; cmd = 1'b0; tach = 1'b0; clr = 1'b0; ena = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    tach_until = tu;
    cmd = 1'b1;
    tach = (tu > 0) ? 1'b1 : 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with random pins.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {spare, clr, tach, cmd} = 8'($urandom);
      uio_in = 8'($urandom);
      @(negedge clk);
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'hFF);
    end
    spare = '0; uio_in = '0;

    // Normal start, continuous tach with 4 edges per window.
    start(1000);
    expect_at(2,  "norm_lat",    8'h00, 8'h00, 1'b1);
    expect_at(3,  "norm_spinup", 8'h10, 8'h00, 1'b1);
    expect_at(18, "norm_pre",    8'h10, 8'h00, 1'b1);
    expect_at(19, "norm_run",    8'h21, 8'h04, 1'b1);
    expect_at(35, "norm_hold",   8'h21, 8'h04, 1'b1);
    expect_at(51, "norm_hold2",  8'h21, 8'h04, 1'b1);
    run_to(52);

    // Stall: tach stops after the first window, then mid-run reset.
    start(16);
    expect_at(19, "stall_run",  8'h21, 8'h04, 1'b1);
    expect_at(34, "stall_pre",  8'h21, 8'h04, 1'b1);
    expect_at(35, "stall_flt",  8'h3A, 8'h00, 1'b1);
    expect_at(40, "stall_hold", 8'h3A, 8'h00, 1'b1);
    run_to(40);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_uo", uo_out, 8'h00);
    chk("midrst_uio", uio_out, 8'h00);

    // cmd drop lands on an empty window close: no fault.
    start(16);
    expect_at(34, "drop_pre",  8'h21, 8'h04, 1'b1);
    expect_at(35, "drop_idle", 8'h00, 8'h00, 1'b0);
    expect_at(40, "drop_hold", 8'h00, 8'h00, 1'b0);
    run_to(32);
    cmd = 1'b0;
    run_to(40);

    // No-start, clear handling and edge-qualified restart.
    start(0);
    expect_at(50, "ns_pre",      8'h10, 8'h00, 1'b1);
    expect_at(51, "ns_flt",      8'h36, 8'h00, 1'b1);
    expect_at(65, "ns_clr_cmd1", 8'h36, 8'h00, 1'b0);
    expect_at(75, "ns_cmd0",     8'h36, 8'h00, 1'b0);
    expect_at(77, "ns_clr_lat",  8'h36, 8'h00, 1'b0);
    expect_at(78, "ns_cleared",  8'h00, 8'h00, 1'b1);
    expect_at(90, "ns_noarm",    8'h00, 8'h00, 1'b0);
    expect_at(97, "ns_re_pre",   8'h00, 8'h00, 1'b0);
    expect_at(98, "ns_restart",  8'h10, 8'h00, 1'b0);
    run_to(55);
    clr = 1'b1;
    run_to(65);
    cmd = 1'b0; clr = 1'b0;
    run_to(75);
    clr = 1'b1;
    run_to(76);
    cmd = 1'b1;
    run_to(90);
    cmd = 1'b0; clr = 1'b0;
    run_to(95);
    cmd = 1'b1;
    run_to(98);

    // ena low for 10 cycles pushes the no-start fault out by 10.
    start(0);
    expect_at(19, "ena_w1",   8'h10, 8'h00, 1'b1);
    expect_at(51, "ena_late", 8'h10, 8'h00, 1'b1);
    expect_at(60, "ena_pre",  8'h10, 8'h00, 1'b1);
    expect_at(61, "ena_flt",  8'h36, 8'h00, 1'b1);
    run_to(10);
    ena = 1'b0;
    run_to(20);
    ena = 1'b1;
    run_to(62);

    chk("sb_leftover", 8'(sbq.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
